// File: rtl/csr_spmv_row_engine.sv
// csr_spmv_row_engine
// Sequential CSR sparse-matrix x dense-vector engine. For each row in
// [row_first, row_first+row_count) it walks the rowptr/val/col arrays and the
// x vector through synchronous 1-cycle read ports. It accumulates
// val*x[col] with either saturating or wrapping arithmetic and streams one
// result per row on a valid/ready interface.
//
// Read addresses are registered outputs. Each address is placed on its port
// one state ahead of the state that consumes the returned data. The
// next-nonzero address is prefetched while the current product is being
// formed, which keeps every nonzero at three cycles (NZ_RD, X_RD, MAC).
module csr_spmv_row_engine #(
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 64,
    parameter int N_ROWS  = 64,
    parameter int M_COLS  = 64,
    parameter int NNZ_MAX = 1024,
    parameter int SAT     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(N_ROWS)-1:0]      row_first,
    input  logic [$clog2(N_ROWS):0]        row_count,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [$clog2(N_ROWS+1)-1:0]    rp_addr,
    input  logic [$clog2(NNZ_MAX+1)-1:0]   rp_data,
    output logic [$clog2(NNZ_MAX)-1:0]     nz_addr,
    input  logic [DATA_W-1:0]              val_data,
    input  logic [$clog2(M_COLS):0]        col_data,
    output logic [$clog2(M_COLS)-1:0]      x_addr,
    input  logic [DATA_W-1:0]              x_data,
    output logic                           y_valid,
    input  logic                           y_ready,
    output logic [$clog2(N_ROWS)-1:0]      y_row,
    output logic [ACC_W-1:0]               y_data
);

    localparam int RW = $clog2(N_ROWS);
    localparam int PW = $clog2(N_ROWS + 1);
    localparam int NW = $clog2(NNZ_MAX + 1);
    localparam int AW = $clog2(NNZ_MAX);
    localparam int XW = $clog2(M_COLS);

    typedef enum logic [3:0] {
        IDLE, RP_LO, RP_HI, ROW_CHK, NZ_RD, X_RD, MAC, OUT, FIN
    } state_t;

    state_t state, state_nxt;

    logic [RW-1:0]              r;
    logic [RW:0]                remaining;
    logic [NW-1:0]              lo, hi, i, i_inc;
    logic signed [DATA_W-1:0]   val_p;
    logic                       zero_p;
    logic signed [ACC_W-1:0]    acc, acc_nxt;
    logic signed [2*DATA_W-1:0] prod;
    logic                       rp_bad, row_empty, last_nz, more_rows, row_wrap, col_bad;

    // Add a product to the accumulator; clamp at the signed limits when SAT is set.
    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0]    a,
                                                       input logic signed [2*DATA_W-1:0] p);
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(p);
        if (SAT != 0 && s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    // In ROW_CHK rp_data carries hi; in NZ_RD col_data carries the column index.
    assign rp_bad    = (rp_data < lo) || (int'(rp_data) > NNZ_MAX);
    assign row_empty = (rp_data == lo);
    assign i_inc     = i + NW'(1);
    assign last_nz   = (i_inc == hi);
    assign more_rows = (remaining > (RW+1)'(1));
    assign row_wrap  = (r == RW'(N_ROWS - 1));
    assign col_bad   = (int'(col_data) >= M_COLS);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (row_count == '0) ? FIN : RP_LO;
            RP_LO:   state_nxt = RP_HI;
            RP_HI:   state_nxt = ROW_CHK;
            ROW_CHK: state_nxt = (rp_bad || row_empty) ? OUT : NZ_RD;
            NZ_RD:   state_nxt = X_RD;
            X_RD:    state_nxt = MAC;
            MAC:     state_nxt = last_nz ? OUT : NZ_RD;
            OUT:     if (y_ready) state_nxt = (more_rows && !row_wrap) ? RP_LO : FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Product of the captured value with x; an out-of-range column contributes zero.
    always_comb begin
        prod = '0;
        if (!zero_p) prod = (2*DATA_W)'(val_p) * (2*DATA_W)'($signed(x_data));
        acc_nxt = acc_add(acc, prod);
    end

    // Control, addresses, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            y_valid   <= 1'b0;
            y_row     <= '0;
            y_data    <= '0;
            rp_addr   <= '0;
            nz_addr   <= '0;
            x_addr    <= '0;
            acc       <= '0;
            r         <= '0;
            remaining <= '0;
        end else begin
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == FIN);
            y_valid <= (state_nxt == OUT);
            case (state)
                IDLE: if (start) begin
                    r         <= row_first;
                    remaining <= row_count;
                    err       <= 1'b0;
                    rp_addr   <= PW'(row_first);
                end
                RP_LO:   rp_addr <= PW'(r) + PW'(1);
                RP_HI:   nz_addr <= AW'(rp_data);
                ROW_CHK: begin
                    acc <= '0;
                    if (rp_bad) err <= 1'b1;
                    if (rp_bad || row_empty) begin
                        y_row  <= r;
                        y_data <= '0;
                    end
                end
                NZ_RD: begin
                    nz_addr <= AW'(i_inc);
                    if (col_bad) err <= 1'b1;
                    else         x_addr <= XW'(col_data);
                end
                MAC: begin
                    acc <= acc_nxt;
                    if (last_nz) begin
                        y_row  <= r;
                        y_data <= acc_nxt;
                    end
                end
                OUT: if (y_ready) begin
                    remaining <= remaining - (RW+1)'(1);
                    if (more_rows && row_wrap) begin
                        err <= 1'b1;
                    end else if (more_rows) begin
                        r       <= r + RW'(1);
                        rp_addr <= PW'(r) + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Row bounds, nonzero index and the captured value/column flag.
    always_ff @(posedge clk) begin
        case (state)
            RP_HI: begin
                lo <= rp_data;
                i  <= rp_data;
            end
            ROW_CHK: hi <= rp_data;
            NZ_RD: begin
                val_p  <= $signed(val_data);
                zero_p <= col_bad;
            end
            MAC:     i <= i_inc;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_spmv_row_engine.sv
// tb_csr_spmv_row_engine
// Directed bench: small rowptr/val/col/x memories behind synchronous read
// ports. It drives jobs into a saturating instance and a wrapping instance,
// and compares streamed results, latencies and flags against hand-computed
// values.
module tb_csr_spmv_row_engine;

    logic        clk = 1'b0;
    logic        rst, start, y_ready;
    logic [2:0]  row_first;
    logic [3:0]  row_count;
    logic        busy, done, err, y_valid;
    logic [3:0]  rp_addr;
    logic [6:0]  rp_data;
    logic [5:0]  nz_addr;
    logic [31:0] val_data, x_data;
    logic [2:0]  col_data, y_row;
    logic [1:0]  x_addr;
    logic [63:0] y_data;

    logic        w_busy, w_done, w_err, w_y_valid;
    logic        w_y_ready = 1'b1;
    logic [3:0]  w_rp_addr;
    logic [6:0]  w_rp_data;
    logic [5:0]  w_nz_addr;
    logic [31:0] w_val_data, w_x_data;
    logic [2:0]  w_col_data, w_y_row;
    logic [1:0]  w_x_addr;
    logic [63:0] w_y_data;

    logic [6:0]  rowptr [0:15];
    logic [31:0] vmem   [0:63];
    logic [2:0]  cmem   [0:63];
    logic [31:0] xmem   [0:3];

    int          cyc = 0;
    int          n_chk = 0, n_err = 0;
    int          n_got = 0, n_done = 0, w_got = 0, w_ndone = 0;
    int          got_row [0:63];
    logic [63:0] got_data [0:63];
    int          got_cyc [0:63];
    logic [63:0] w_last = '0;
    int          g0, d0, start_cyc, rel_cyc, k;

    csr_spmv_row_engine #(.DATA_W(32), .ACC_W(64), .N_ROWS(8), .M_COLS(4), .NNZ_MAX(64), .SAT(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .row_first(row_first), .row_count(row_count),
        .busy(busy), .done(done), .err(err),
        .rp_addr(rp_addr), .rp_data(rp_data), .nz_addr(nz_addr), .val_data(val_data),
        .col_data(col_data), .x_addr(x_addr), .x_data(x_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_row(y_row), .y_data(y_data)
    );

    csr_spmv_row_engine #(.DATA_W(32), .ACC_W(64), .N_ROWS(8), .M_COLS(4), .NNZ_MAX(64), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .row_first(row_first), .row_count(row_count),
        .busy(w_busy), .done(w_done), .err(w_err),
        .rp_addr(w_rp_addr), .rp_data(w_rp_data), .nz_addr(w_nz_addr), .val_data(w_val_data),
        .col_data(w_col_data), .x_addr(w_x_addr), .x_data(w_x_data),
        .y_valid(w_y_valid), .y_ready(w_y_ready), .y_row(w_y_row), .y_data(w_y_data)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous 1-cycle-latency memories for both instances.
    always @(posedge clk) begin
        rp_data    <= rowptr[rp_addr];
        val_data   <= vmem[nz_addr];
        col_data   <= cmem[nz_addr];
        x_data     <= xmem[x_addr];
        w_rp_data  <= rowptr[w_rp_addr];
        w_val_data <= vmem[w_nz_addr];
        w_col_data <= cmem[w_nz_addr];
        w_x_data   <= xmem[w_x_addr];
    end

    // Record result handshakes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (y_valid && y_ready) begin
            if (n_got < 64) begin
                got_row[n_got]  = int'(y_row);
                got_data[n_got] = y_data;
                got_cyc[n_got]  = cyc;
            end
            n_got++;
        end
        if (done) n_done++;
        if (w_y_valid) begin
            w_last = w_y_data;
            w_got++;
        end
        if (w_done) w_ndone++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int j = 0; j < 16; j++) rowptr[j] = '0;
        for (int j = 0; j < 64; j++) begin
            vmem[j] = '0;
            cmem[j] = '0;
        end
        for (int j = 0; j < 4; j++) xmem[j] = '0;
    endtask

    task automatic load_a();
        clear_mem();
        rowptr[0] = 0; rowptr[1] = 2; rowptr[2] = 3; rowptr[3] = 5;
        vmem[0] = 1; vmem[1] = 2; vmem[2] = 3; vmem[3] = 4; vmem[4] = 5;
        cmem[0] = 0; cmem[1] = 2; cmem[2] = 1; cmem[3] = 0; cmem[4] = 2;
        xmem[0] = 10; xmem[1] = 20; xmem[2] = 30;
    endtask

    task automatic pulse_start(input int first, input int count);
        row_first = 3'(first);
        row_count = 4'(count);
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (n_done == d0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", 64'(n_done != d0), 1);
    endtask

    task automatic run_job(input int first, input int count);
        g0 = n_got;
        d0 = n_done;
        pulse_start(first, count);
        wait_done(400);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_yvalid"}, y_valid, 0);
        chk({tag, "_ydata"}, y_data, 0);
        chk({tag, "_yrow"}, y_row, 0);
        chk({tag, "_rpaddr"}, rp_addr, 0);
        chk({tag, "_nzaddr"}, nz_addr, 0);
        chk({tag, "_xaddr"}, x_addr, 0);
    endtask

    task automatic check_a(input string tag);
        chk({tag, "_count"}, n_got - g0, 3);
        chk({tag, "_row0"}, got_row[g0], 0);
        chk({tag, "_y0"}, got_data[g0], 70);
        chk({tag, "_row1"}, got_row[g0+1], 1);
        chk({tag, "_y1"}, got_data[g0+1], 60);
        chk({tag, "_row2"}, got_row[g0+2], 2);
        chk({tag, "_y2"}, got_data[g0+2], 190);
        chk({tag, "_lat0"}, got_cyc[g0] - start_cyc - 1, 9);
        chk({tag, "_ndone"}, n_done - d0, 1);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; y_ready = 1'b1; row_first = '0; row_count = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check_zero("reset");

        // 3x3 job with a 5-cycle stall on row 1 and an ignored start while busy.
        load_a();
        g0 = n_got; d0 = n_done;
        pulse_start(0, 3);
        k = 0;
        while (n_got == g0 && k < 100) begin @(posedge clk); #1; k++; end
        y_ready = 1'b0;
        k = 0;
        while (!y_valid && k < 50) begin @(posedge clk); #1; k++; end
        for (int s = 0; s < 5; s++) begin
            chk("bp_valid", y_valid, 1);
            chk("bp_data", y_data, 60);
            chk("bp_row", y_row, 1);
            chk("bp_nohs", n_got - g0, 1);
            @(posedge clk); #1;
        end
        row_first = 3'd5; row_count = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; y_ready = 1'b1; rel_cyc = cyc;
        wait_done(400);
        check_a("bp");
        chk("bp_row2_after_release", got_cyc[g0+2] - rel_cyc, 10);
        repeat (3) @(posedge clk);
        #1;
        chk("ignored_start_busy", busy, 0);
        chk("ignored_start_nores", n_got - g0, 3);

        // Empty row, lo = hi = 3.
        clear_mem();
        rowptr[0] = 3; rowptr[1] = 3;
        run_job(0, 1);
        chk("empty_y", got_data[g0], 0);
        chk("empty_lat", got_cyc[g0] - start_cyc - 1, 3);
        chk("empty_err", err, 0);

        // Twenty nonzeros in one row.
        clear_mem();
        rowptr[0] = 0; rowptr[1] = 20;
        for (int j = 0; j < 20; j++) begin vmem[j] = 1; cmem[j] = 3; end
        xmem[3] = 1;
        run_job(0, 1);
        chk("nz20_y", got_data[g0], 20);
        chk("nz20_lat", got_cyc[g0] - start_cyc - 1, 63);
        chk("nz20_err", err, 0);

        // Three (-2^31)*(-2^31) products: saturate vs wrap.
        clear_mem();
        rowptr[0] = 0; rowptr[1] = 3;
        for (int j = 0; j < 3; j++) vmem[j] = 32'h8000_0000;
        xmem[0] = 32'h8000_0000;
        k = w_got;
        run_job(0, 1);
        chk("sat_y", got_data[g0], 64'h7FFF_FFFF_FFFF_FFFF);
        chk("wrap_y", w_last, 64'hC000_0000_0000_0000);
        chk("wrap_got", w_got - k, 1);
        chk("wrap_row", w_y_row, 0);
        chk("wrap_err", w_err, 0);
        chk("wrap_busy", w_busy, 0);

        // Column out of range: product dropped, err sticky until next start.
        clear_mem();
        rowptr[0] = 0; rowptr[1] = 2;
        vmem[0] = 2; vmem[1] = 3; cmem[0] = 7; cmem[1] = 1; xmem[1] = 5;
        run_job(0, 1);
        chk("col_y", got_data[g0], 15);
        chk("col_err", err, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("col_err_sticky", err, 1);
        g0 = n_got; d0 = n_done;
        pulse_start(0, 0);
        chk("zero_job_err_clr", err, 0);
        chk("zero_job_done", done, 1);
        chk("zero_job_busy", busy, 1);
        wait_done(20);
        chk("zero_job_nores", n_got - g0, 0);
        chk("zero_job_idle", busy, 0);

        // Bad rowptr: hi < lo, then hi > NNZ_MAX.
        clear_mem();
        rowptr[0] = 5; rowptr[1] = 2; rowptr[2] = 100;
        run_job(0, 1);
        chk("hilo_y", got_data[g0], 0);
        chk("hilo_err", err, 1);
        run_job(1, 1);
        chk("himax_y", got_data[g0], 0);
        chk("himax_row", got_row[g0], 1);
        chk("himax_err", err, 1);

        // Row index wrap-around past the last row.
        clear_mem();
        run_job(7, 2);
        chk("wrap_rows", n_got - g0, 1);
        chk("wrap_lastrow", got_row[g0], 7);
        chk("wrap_errflag", err, 1);

        // Reset during MAC of row 1, then restart the job.
        load_a();
        g0 = n_got; d0 = n_done;
        pulse_start(0, 3);
        repeat (15) begin @(posedge clk); #1; end
        chk("rst_row0_out", n_got - g0, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_zero("rst_mid");
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_done", n_done - d0, 0);
        chk("rst_idle", busy, 0);
        run_job(0, 3);
        check_a("restart");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
